// File: rtl/spi_master_tx_if.sv
// Host-side byte stream for spi_master_tx.
//   tx_data/tx_last/tx_valid : byte offered by the upstream, tx_last ends the frame
//   tx_ready                 : block accepts a byte on this cycle's edge
//   rx_data/rx_valid         : byte captured from MISO, rx_valid is a one-cycle pulse
//   busy                     : select asserted or inter-frame gap running
// master = upstream producer/consumer, slave = spi_master_tx.
interface spi_master_tx_if;
    logic [7:0] tx_data;
    logic       tx_last;
    logic       tx_valid;
    logic       tx_ready;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       busy;

    modport master (
        output tx_data, tx_last, tx_valid,
        input  tx_ready, rx_data, rx_valid, busy
    );

    modport slave (
        input  tx_data, tx_last, tx_valid,
        output tx_ready, rx_data, rx_valid, busy
    );
endinterface

// File: rtl/spi_master_tx.sv
// SPI mode-0 master transmitter (CPOL=0, CPHA=0), MSB first, 8-bit words,
// active-low select. Full duplex: MISO is captured on every SCK rise.
// A per-byte last flag keeps SSEL low across multi-byte frames; after the
// last byte SSEL rises one half-period after the final SCK fall and stays
// high for at least GAP_HALVES half-periods.
//
// Ports:
//   clk, rst_n    system clock, asynchronous active-low reset
//   host          byte handshake (spi_master_tx_if.slave)
//   spi_ssel      chip select, active low
//   spi_sck       serial clock, idles low
//   spi_mosi      serial data out
//   spi_miso      serial data in (sampled on the internal SCK-rise edge)
//
// Parameters:
//   CLK_DIV       system clocks per SCK half-period (1..255)
//   GAP_HALVES    minimum SSEL-high half-periods between frames (1..15)
module spi_master_tx #(
    parameter int CLK_DIV    = 4,
    parameter int GAP_HALVES = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    spi_master_tx_if.slave    host,
    output logic              spi_ssel,
    output logic              spi_sck,
    output logic              spi_mosi,
    input  logic              spi_miso
);

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        HOLD,
        GAP
    } state_t;

    localparam logic [7:0] HMAX = 8'(CLK_DIV - 1);
    localparam logic [3:0] GMAX = 4'(GAP_HALVES - 1);

    state_t     state, state_d;
    logic [7:0] hcnt;       // system clocks within the current half-period
    logic [2:0] bcnt;       // bit index within the byte (0 = MSB)
    logic [3:0] gcnt;       // half-periods spent in GAP
    logic [6:0] tx_sh;      // remaining bits; bit 7 goes straight to MOSI on accept
    logic [7:0] rx_sh;
    logic [7:0] rx_data_q;
    logic       rx_valid_q;
    logic       last_q;
    logic       trail;      // trailing half-period after the final fall of a frame

    logic       tx_ready_c;
    logic       accept;
    logic       half_tick;
    logic       byte_done;
    logic       trail_done;
    logic       gap_done;

    assign tx_ready_c = (state == IDLE) || (state == HOLD);
    assign accept     = host.tx_valid && tx_ready_c;
    assign half_tick  = (hcnt == HMAX);

    // The eighth SCK fall: SCK is high on a tick and all bits are out.
    assign byte_done  = (state == SHIFT) && half_tick && spi_sck && !trail && (bcnt == 3'd7);
    assign trail_done = (state == SHIFT) && half_tick && trail;
    assign gap_done   = (state == GAP) && half_tick && (gcnt == GMAX);

    assign host.tx_ready = tx_ready_c;
    assign host.rx_data  = rx_data_q;
    assign host.rx_valid = rx_valid_q;
    assign host.busy     = !spi_ssel || (state == GAP);

    // ---------------------------------------------------------------
    // State register
    // ---------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_d;
        end
    end

    // ---------------------------------------------------------------
    // Next-state logic
    // ---------------------------------------------------------------
    always_comb begin
        state_d = state;
        case (state)
            IDLE: begin
                if (accept) begin
                    state_d = SHIFT;
                end
            end
            HOLD: begin
                if (accept) begin
                    state_d = SHIFT;
                end
            end
            SHIFT: begin
                if (trail_done) begin
                    state_d = GAP;
                end else if (byte_done && !last_q) begin
                    state_d = HOLD;
                end
            end
            GAP: begin
                if (gap_done) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // ---------------------------------------------------------------
    // Datapath: half-period timing, shifters, pin registers
    // ---------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hcnt       <= 8'd0;
            bcnt       <= 3'd0;
            gcnt       <= 4'd0;
            tx_sh      <= 7'd0;
            rx_sh      <= 8'd0;
            rx_data_q  <= 8'd0;
            rx_valid_q <= 1'b0;
            last_q     <= 1'b0;
            trail      <= 1'b0;
            spi_ssel   <= 1'b1;
            spi_sck    <= 1'b0;
            spi_mosi   <= 1'b0;
        end else begin
            rx_valid_q <= 1'b0;
            if (accept) begin
                // Cycle 0 of a byte: timing restarts from here, even out of HOLD.
                tx_sh    <= host.tx_data[6:0];
                last_q   <= host.tx_last;
                spi_ssel <= 1'b0;
                spi_sck  <= 1'b0;
                spi_mosi <= host.tx_data[7];
                hcnt     <= 8'd0;
                bcnt     <= 3'd0;
                trail    <= 1'b0;
            end else begin
                case (state)
                    SHIFT: begin
                        hcnt <= half_tick ? 8'd0 : hcnt + 8'd1;
                        if (half_tick) begin
                            if (trail) begin
                                // End of the trailing half-period: release select.
                                spi_ssel <= 1'b1;
                                trail    <= 1'b0;
                                gcnt     <= 4'd0;
                            end else if (!spi_sck) begin
                                // Rising edge: sample MISO alongside raising SCK.
                                spi_sck <= 1'b1;
                                rx_sh   <= {rx_sh[6:0], spi_miso};
                            end else begin
                                spi_sck <= 1'b0;
                                if (bcnt == 3'd7) begin
                                    // MOSI keeps bit 0 through HOLD / the trail.
                                    rx_data_q  <= rx_sh;
                                    rx_valid_q <= 1'b1;
                                    trail      <= last_q;
                                end else begin
                                    bcnt     <= bcnt + 3'd1;
                                    spi_mosi <= tx_sh[6];
                                    tx_sh    <= {tx_sh[5:0], 1'b0};
                                end
                            end
                        end
                    end
                    GAP: begin
                        hcnt <= half_tick ? 8'd0 : hcnt + 8'd1;
                        if (half_tick) begin
                            gcnt <= gcnt + 4'd1;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_spi_master_tx.sv
module tb_spi_master_tx;
    localparam int H = 2;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic spi_ssel, spi_sck, spi_mosi, spi_miso;
    bit   miso_mode = 1'b0;   // 0: loopback from MOSI, 1: constant 1

    spi_master_tx_if bus ();

    spi_master_tx #(.CLK_DIV(H), .GAP_HALVES(1)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .host     (bus),
        .spi_ssel (spi_ssel),
        .spi_sck  (spi_sck),
        .spi_mosi (spi_mosi),
        .spi_miso (spi_miso)
    );

    assign spi_miso = miso_mode ? 1'b1 : spi_mosi;

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;
    int ecnt = 0;

    always @(posedge clk) ecnt <= ecnt + 1;

    // Scoreboard and wire monitors
    logic [7:0] exp_q[$];
    logic [7:0] obs_q[$];
    int         obs_cyc_q[$];
    int         rise_cyc_q[$];
    bit         rise_bit_q[$];
    logic [7:0] frm_q[$];      // bytes decoded by the slave-receiver model
    int         ssel_rise_cnt = 0;
    logic       prev_sck = 1'b0;
    logic       prev_ssel = 1'b1;
    logic [7:0] sreg = 8'd0;
    int         nb = 0;

    always @(negedge clk) begin
        if (spi_sck && !prev_sck) begin
            rise_cyc_q.push_back(ecnt);
            rise_bit_q.push_back(spi_mosi);
            if (!spi_ssel) begin
                sreg = {sreg[6:0], spi_mosi};
                nb++;
                if (nb == 8) begin
                    frm_q.push_back(sreg);
                    nb = 0;
                end
            end
        end
        if (spi_ssel || !rst_n) nb = 0;
        if (spi_ssel && !prev_ssel) ssel_rise_cnt++;
        if (bus.rx_valid) begin
            obs_q.push_back(bus.rx_data);
            obs_cyc_q.push_back(ecnt);
        end
        prev_sck  = spi_sck;
        prev_ssel = spi_ssel;
    end

    task automatic clear_sb();
        @(negedge clk);
        #1;
        exp_q.delete();
        obs_q.delete();
        obs_cyc_q.delete();
        rise_cyc_q.delete();
        rise_bit_q.delete();
        frm_q.delete();
        ssel_rise_cnt = 0;
    endtask

    // Offer a byte, return the edge count of the accepting edge.
    task automatic send(input logic [7:0] d, input bit last, output int acc_e);
        int n = 0;
        @(negedge clk);
        bus.tx_data  = d;
        bus.tx_last  = last;
        bus.tx_valid = 1'b1;
        while (!bus.tx_ready && n < 2000) begin
            @(negedge clk);
            n++;
        end
        if (!bus.tx_ready) begin
            checks++; failures++;
            $display("FAIL send_timeout data=%02h tx_ready never rose", d);
            bus.tx_valid = 1'b0;
            acc_e = -1;
            return;
        end
        @(posedge clk);
        #1;
        acc_e = ecnt - 1;
        bus.tx_valid = 1'b0;
        exp_q.push_back(miso_mode ? 8'hFF : d);
    endtask

    task automatic wait_idle();
        int n = 0;
        @(negedge clk);
        while (!(bus.tx_ready && !bus.busy) && n < 2000) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (!(bus.tx_ready && !bus.busy)) begin
            failures++;
            $display("FAIL idle_timeout got tx_ready=%0b busy=%0b want 1/0", bus.tx_ready, bus.busy);
        end
        #1;
    endtask

    task automatic test_reset();
        bus.tx_valid = 1'b0;
        bus.tx_data  = 8'h00;
        bus.tx_last  = 1'b0;
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if ({spi_ssel, spi_sck, spi_mosi} !== 3'b100) begin
            failures++;
            $display("FAIL reset_pins got ssel/sck/mosi=%b want 100", {spi_ssel, spi_sck, spi_mosi});
        end
        checks++;
        if ({bus.rx_data, bus.rx_valid, bus.busy} !== 10'd0) begin
            failures++;
            $display("FAIL reset_host got rx_data=%02h rx_valid=%0b busy=%0b want 0/0/0",
                     bus.rx_data, bus.rx_valid, bus.busy);
        end
        rst_n = 1'b1;
        repeat (5) @(negedge clk);
        checks++;
        if (bus.tx_ready !== 1'b1) begin
            failures++;
            $display("FAIL reset_ready got %0b want 1", bus.tx_ready);
        end
        checks++;
        if (obs_q.size() != 0) begin
            failures++;
            $display("FAIL reset_rxvalid got %0d pulses want 0", obs_q.size());
        end
    endtask

    task automatic test_single();
        int a, rel, bad;
        logic [7:0] pat;
        miso_mode = 1'b0;
        clear_sb();
        pat = 8'hA5;
        send(pat, 1'b1, a);
        bad = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            rel = ecnt - a;
            if (rel == 34 && spi_ssel !== 1'b0) bad++;
            if (rel == 35 && spi_ssel !== 1'b1) bad++;
            if (rel == 36 && (bus.tx_ready !== 1'b0 || bus.busy !== 1'b1)) bad++;
            if (rel == 37 && (bus.tx_ready !== 1'b1 || bus.busy !== 1'b0)) bad++;
        end
        #1;
        checks++;
        if (bad != 0) begin
            failures++;
            $display("FAIL single_ssel_ready got %0d timing errors want 0 (ssel up @35, ready @37)", bad);
        end
        checks++;
        if (rise_cyc_q.size() != 8) begin
            failures++;
            $display("FAIL single_rises got %0d want 8", rise_cyc_q.size());
        end else begin
            bad = 0;
            for (int k = 0; k < 8; k++) begin
                if (rise_cyc_q[k] - a != 3 + 4 * k) bad++;
                if (rise_bit_q[k] !== pat[7-k]) bad++;
            end
            checks++;
            if (bad != 0) begin
                failures++;
                $display("FAIL single_rise_pattern got %0d errors want 0 (rises @3+4k, bits of A5)", bad);
            end
        end
        checks++;
        if (obs_q.size() != 1 || exp_q.size() != 1) begin
            failures++;
            $display("FAIL single_rx_count got %0d/%0d want 1/1", obs_q.size(), exp_q.size());
        end else begin
            checks++;
            if (obs_q[0] !== exp_q[0] || obs_cyc_q[0] - a != 33) begin
                failures++;
                $display("FAIL single_rx got %02h@%0d want %02h@33", obs_q[0], obs_cyc_q[0] - a, exp_q[0]);
            end
        end
    endtask

    task automatic test_back_to_back();
        int a1, a2;
        logic [7:0] e, o;
        miso_mode = 1'b0;
        clear_sb();
        send(8'h3C, 1'b0, a1);
        send(8'hC3, 1'b1, a2);
        wait_idle();
        checks++;
        if (a2 - a1 != 16 * H + 1) begin
            failures++;
            $display("FAIL b2b_accept_gap got %0d want %0d", a2 - a1, 16 * H + 1);
        end
        checks++;
        if (rise_cyc_q.size() != 16 || ssel_rise_cnt != 1) begin
            failures++;
            $display("FAIL b2b_frame got rises=%0d ssel_rises=%0d want 16/1", rise_cyc_q.size(), ssel_rise_cnt);
        end
        checks++;
        if (obs_q.size() != 2) begin
            failures++;
            $display("FAIL b2b_rx_count got %0d want 2", obs_q.size());
        end
        while (obs_q.size() != 0 && exp_q.size() != 0) begin
            o = obs_q.pop_front();
            e = exp_q.pop_front();
            checks++;
            if (o !== e) begin
                failures++;
                $display("FAIL b2b_rx got %02h want %02h", o, e);
            end
        end
    endtask

    task automatic test_stall();
        int a1, a2, bad, n;
        logic [7:0] e, o;
        miso_mode = 1'b0;
        clear_sb();
        send(8'h01, 1'b0, a1);
        n = 0;
        @(negedge clk);
        while (!bus.tx_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        bad = 0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (spi_ssel !== 1'b0 || spi_sck !== 1'b0 || spi_mosi !== 1'b1 || bus.tx_ready !== 1'b1) bad++;
        end
        checks++;
        if (bad != 0) begin
            failures++;
            $display("FAIL stall_hold got %0d bad cycles want 0 (ssel 0, sck 0, mosi 1)", bad);
        end
        send(8'h80, 1'b1, a2);
        wait_idle();
        checks++;
        if (rise_cyc_q.size() != 16 || rise_cyc_q[8] - a2 != 3) begin
            failures++;
            $display("FAIL stall_second_timing got rises=%0d first_rel=%0d want 16/3",
                     rise_cyc_q.size(), rise_cyc_q.size() > 8 ? rise_cyc_q[8] - a2 : -1);
        end
        checks++;
        if (ssel_rise_cnt != 1 || obs_q.size() != 2) begin
            failures++;
            $display("FAIL stall_frame got ssel_rises=%0d rx=%0d want 1/2", ssel_rise_cnt, obs_q.size());
        end
        while (obs_q.size() != 0 && exp_q.size() != 0) begin
            o = obs_q.pop_front();
            e = exp_q.pop_front();
            checks++;
            if (o !== e) begin
                failures++;
                $display("FAIL stall_rx got %02h want %02h", o, e);
            end
        end
    endtask

    task automatic test_receiver();
        int a;
        logic [7:0] e, o;
        miso_mode = 1'b1;
        clear_sb();
        send(8'h0F, 1'b1, a);
        wait_idle();
        send(8'h05, 1'b1, a);
        wait_idle();
        checks++;
        if (frm_q.size() != 2 || ssel_rise_cnt != 2) begin
            failures++;
            $display("FAIL recv_count got cmds=%0d frames=%0d want 2/2", frm_q.size(), ssel_rise_cnt);
        end else begin
            checks++;
            if (frm_q[0] !== 8'h0F || frm_q[1] !== 8'h05) begin
                failures++;
                $display("FAIL recv_cmd got %02h,%02h want 0f,05", frm_q[0], frm_q[1]);
            end
        end
        checks++;
        if (obs_q.size() != 2) begin
            failures++;
            $display("FAIL recv_rx_count got %0d want 2", obs_q.size());
        end
        while (obs_q.size() != 0 && exp_q.size() != 0) begin
            o = obs_q.pop_front();
            e = exp_q.pop_front();
            checks++;
            if (o !== e) begin
                failures++;
                $display("FAIL recv_miso_rx got %02h want %02h", o, e);
            end
        end
        miso_mode = 1'b0;
    endtask

    task automatic test_abort();
        int a, n;
        logic [7:0] e, o;
        miso_mode = 1'b0;
        clear_sb();
        send(8'hC7, 1'b1, a);
        n = 0;
        while (rise_cyc_q.size() < 3 && n < 200) begin
            @(negedge clk);
            n++;
        end
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if (spi_ssel !== 1'b1 || spi_sck !== 1'b0 || bus.busy !== 1'b0) begin
            failures++;
            $display("FAIL abort_async got ssel=%0b sck=%0b busy=%0b want 1/0/0", spi_ssel, spi_sck, bus.busy);
        end
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        #1;
        checks++;
        if (obs_q.size() != 0 || frm_q.size() != 0) begin
            failures++;
            $display("FAIL abort_no_rx got rx=%0d cmds=%0d want 0/0", obs_q.size(), frm_q.size());
        end
        exp_q.delete();
        send(8'h5A, 1'b1, a);
        wait_idle();
        checks++;
        if (obs_q.size() != 1 || frm_q.size() != 1) begin
            failures++;
            $display("FAIL abort_recover_count got rx=%0d cmds=%0d want 1/1", obs_q.size(), frm_q.size());
        end else begin
            o = obs_q.pop_front();
            e = exp_q.pop_front();
            checks++;
            if (o !== e || frm_q[0] !== 8'h5A) begin
                failures++;
                $display("FAIL abort_recover got rx=%02h cmd=%02h want %02h/5a", o, frm_q[0], e);
            end
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_back_to_back();
        test_stall();
        test_receiver();
        test_abort();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout simulation did not complete");
        $fatal(1, "timeout");
    end

endmodule
